cix_seq: RTL and testbench

Multi-cycle bit-index counter over an operand of WORDS chunks of 2^ORDER bits. Computes count-trailing-zeros, count-leading-zeros, popcount of ones or popcount of zeros. One chunk is processed per clock, with early termination for ctz/clz. It is the wide-operand successor to the single-word combinational counters in the logic library and sits behind a valid/ready handshake so it can be dropped into streaming datapaths.

---
 rtl/cix_seq_pkg.sv | 19 +
 rtl/cix_chunk.sv | 45 ++++
 rtl/cix_seq.sv | 127 ++++++++++++
 tb/tb_cix_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cix_seq_pkg.sv
// cix_seq_pkg: shared encodings for the cix_seq bit-index counter.
//   cix_mode_e  : operation select (ctz, clz, popcount ones, popcount zeros)
//   cix_state_e : sequencer states
package cix_seq_pkg;

    typedef enum logic [1:0] {
        CIX_CTZ  = 2'b00,
        CIX_CLZ  = 2'b01,
        CIX_POP1 = 2'b10,
        CIX_POP0 = 2'b11
    } cix_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } cix_state_e;

endpackage

// File: rtl/cix_chunk.sv
// cix_chunk: combinational per-chunk counter for one W = 2^ORDER bit chunk.
//   chunk   : W-bit slice of the operand
//   mode    : operation select
//   count   : ctz/clz -> trailing/leading zeros (W when chunk is zero),
//             pop1 -> ones, pop0 -> zeros
//   nonzero : chunk has at least one bit set
module cix_chunk
    import cix_seq_pkg::*;
#(
    parameter int ORDER = 3
) (
    input  logic [2**ORDER-1:0] chunk,
    input  cix_mode_e           mode,
    output logic [ORDER:0]      count,
    output logic                nonzero
);
    localparam int W = 2**ORDER;

    logic [ORDER:0] ones;
    logic [ORDER:0] tz;
    logic [ORDER:0] lz;

    always_comb begin
        ones = '0;
        tz   = (ORDER+1)'(W);
        lz   = (ORDER+1)'(W);
        for (int i = 0; i < W; i++)
            ones = ones + (ORDER+1)'(chunk[i]);
        // Scan downward so the lowest set bit wins.
        for (int i = W-1; i >= 0; i--)
            if (chunk[i]) tz = (ORDER+1)'(i);
        // Scan upward so the highest set bit wins.
        for (int i = 0; i < W; i++)
            if (chunk[i]) lz = (ORDER+1)'(W-1-i);
        case (mode)
            CIX_CTZ:  count = tz;
            CIX_CLZ:  count = lz;
            CIX_POP1: count = ones;
            default:  count = (ORDER+1)'(W) - ones;
        endcase
    end

    assign nonzero = |chunk;

endmodule

// File: rtl/cix_seq.sv
// cix_seq: multi-cycle ctz / clz / popcount over WORDS chunks of 2^ORDER bits,
// one chunk per clock, early exit for ctz/clz, valid/ready on both sides.
//   clock, reset     : clock, asynchronous active-high reset
//   in_valid/in_ready: request handshake (ready only in IDLE)
//   in_mode, in_data : operation and N-bit operand
//   out_valid/out_ready : result handshake (valid only in DONE)
//   out_count        : RW-bit result
//   out_zero         : ctz/clz no bit set; popcount result is zero
module cix_seq
    import cix_seq_pkg::*;
#(
    parameter  int ORDER = 3,
    parameter  int WORDS = 4,
    localparam int W     = 2**ORDER,
    localparam int N     = W * WORDS,
    localparam int RW    = $clog2(N+1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_mode,
    input  logic [N-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_count,
    output logic          out_zero
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    cix_state_e    state, state_d;
    cix_mode_e     mode_q, mode_d;
    logic [N-1:0]  data_q, data_d;
    logic [IW-1:0] idx, idx_d;
    logic [RW-1:0] acc, acc_d, step_sum;
    logic          zero_q, zero_d;

    logic [W-1:0]   chunk;
    logic [ORDER:0] chunk_cnt;
    logic           chunk_nz;
    logic           last;

    assign chunk = data_q[int'(idx)*W +: W];

    cix_chunk #(.ORDER(ORDER)) u_chunk (
        .chunk   (chunk),
        .mode    (mode_q),
        .count   (chunk_cnt),
        .nonzero (chunk_nz)
    );

    // clz walks from the top chunk down, everything else from chunk 0 up.
    assign last     = (mode_q == CIX_CLZ) ? (idx == '0) : (idx == IW'(WORDS-1));
    assign step_sum = acc + RW'(chunk_cnt);

    always_comb begin
        state_d = state;
        mode_d  = mode_q;
        data_d  = data_q;
        idx_d   = idx;
        acc_d   = acc;
        zero_d  = zero_q;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_d = BUSY;
                    mode_d  = cix_mode_e'(in_mode);
                    data_d  = in_data;
                    acc_d   = '0;
                    zero_d  = 1'b0;
                    idx_d   = (cix_mode_e'(in_mode) == CIX_CLZ) ? IW'(WORDS-1) : '0;
                end
            end
            BUSY: begin
                // A zero chunk contributes W in ctz/clz, so an all-zero
                // operand naturally accumulates to N.
                acc_d = step_sum;
                if (mode_q == CIX_CTZ || mode_q == CIX_CLZ) begin
                    if (chunk_nz) begin
                        state_d = DONE;
                        zero_d  = 1'b0;
                    end else if (last) begin
                        state_d = DONE;
                        zero_d  = 1'b1;
                    end else begin
                        idx_d = (mode_q == CIX_CLZ) ? idx - 1'b1 : idx + 1'b1;
                    end
                end else begin
                    if (last) begin
                        state_d = DONE;
                        zero_d  = (step_sum == '0);
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            mode_q <= CIX_CTZ;
            data_q <= '0;
            idx    <= '0;
            acc    <= '0;
            zero_q <= 1'b0;
        end else begin
            state  <= state_d;
            mode_q <= mode_d;
            data_q <= data_d;
            idx    <= idx_d;
            acc    <= acc_d;
            zero_q <= zero_d;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_count = acc;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_cix_seq.sv
// tb_cix_seq: scoreboard bench for cix_seq. DUT a is ORDER=3/WORDS=4,
// DUT b is ORDER=3/WORDS=1. Drivers push expected results with the accept
// edge; monitors pop and compare on the first cycle of out_valid.
module tb_cix_seq;
    import cix_seq_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        a_iv, a_ir, a_ov, a_or, a_z;
    logic [1:0]  a_mode;
    logic [31:0] a_data;
    logic [5:0]  a_cnt;

    logic        b_iv, b_ir, b_ov, b_or, b_z;
    logic [1:0]  b_mode;
    logic [7:0]  b_data;
    logic [3:0]  b_cnt;

    cix_seq #(.ORDER(3), .WORDS(4)) dut_a (
        .clock(clock), .reset(reset),
        .in_valid(a_iv), .in_ready(a_ir), .in_mode(a_mode), .in_data(a_data),
        .out_valid(a_ov), .out_ready(a_or), .out_count(a_cnt), .out_zero(a_z)
    );

    cix_seq #(.ORDER(3), .WORDS(1)) dut_b (
        .clock(clock), .reset(reset),
        .in_valid(b_iv), .in_ready(b_ir), .in_mode(b_mode), .in_data(b_data),
        .out_valid(b_ov), .out_ready(b_or), .out_count(b_cnt), .out_zero(b_z)
    );

    typedef struct {
        int cnt;
        bit z;
        int t0;
        int lat;
    } exp_t;

    typedef struct {
        logic [1:0]  m;
        logic [31:0] d;
        int          c;
        bit          z;
        int          lat;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor for DUT a: compare on out_valid rise, then require the
    // result to stay put for as long as out_valid is held.
    bit a_prev = 1'b0;
    int a_hold_c;
    bit a_hold_z;
    always @(negedge clock) begin : mon_a
        exp_t e;
        if (reset) a_prev = 1'b0;
        else begin
            if (a_ov && !a_prev) begin
                if (qa.size() == 0) chk("a_unexpected_out", 1, 0);
                else begin
                    e = qa.pop_front();
                    chk("a_count", int'(a_cnt), e.cnt);
                    chk("a_zero", int'(a_z), int'(e.z));
                    chk("a_latency", cyc - e.t0, e.lat);
                end
                a_hold_c = int'(a_cnt);
                a_hold_z = a_z;
            end else if (a_ov) begin
                chk("a_hold_count", int'(a_cnt), a_hold_c);
                chk("a_hold_zero", int'(a_z), int'(a_hold_z));
            end
            a_prev = a_ov;
        end
    end

    bit b_prev = 1'b0;
    always @(negedge clock) begin : mon_b
        exp_t e;
        if (reset) b_prev = 1'b0;
        else begin
            if (b_ov && !b_prev) begin
                if (qb.size() == 0) chk("b_unexpected_out", 1, 0);
                else begin
                    e = qb.pop_front();
                    chk("b_count", int'(b_cnt), e.cnt);
                    chk("b_zero", int'(b_z), int'(e.z));
                    chk("b_latency", cyc - e.t0, e.lat);
                end
            end
            b_prev = b_ov;
        end
    end

    // Present a request, wait (bounded) for acceptance, push expectation.
    task automatic issue_a(input logic [1:0] m, input logic [31:0] d, input int c,
                           input bit z, input int lat, output int t0);
        int n = 0;
        @(negedge clock);
        a_iv = 1'b1; a_mode = m; a_data = d;
        while (!a_ir && n < 100) begin @(negedge clock); n++; end
        if (!a_ir) begin
            chk("a_accept_timeout", 0, 1);
            a_iv = 1'b0;
            t0 = -1;
            return;
        end
        t0 = cyc + 1;
        qa.push_back('{c, z, t0, lat});
        @(posedge clock);
        #1 a_iv = 1'b0;
    endtask

    task automatic wait_a();
        int n = 0;
        while ((qa.size() != 0 || !a_ir) && n < 200) begin @(negedge clock); #1; n++; end
        if (n >= 200) begin
            chk("a_done_timeout", 0, 1);
            qa.delete();
        end
    endtask

    task automatic issue_b(input logic [1:0] m, input logic [7:0] d, input int c,
                           input bit z, input int lat);
        int n = 0;
        @(negedge clock);
        b_iv = 1'b1; b_mode = m; b_data = d;
        while (!b_ir && n < 100) begin @(negedge clock); n++; end
        if (!b_ir) begin
            chk("b_accept_timeout", 0, 1);
            b_iv = 1'b0;
            return;
        end
        qb.push_back('{c, z, cyc + 1, lat});
        @(posedge clock);
        #1 b_iv = 1'b0;
    endtask

    task automatic wait_b();
        int n = 0;
        while ((qb.size() != 0 || !b_ir) && n < 200) begin @(negedge clock); #1; n++; end
        if (n >= 200) begin
            chk("b_done_timeout", 0, 1);
            qb.delete();
        end
    endtask

    // Behavioural reference for an 8-bit operand.
    task automatic model8(input logic [1:0] m, input logic [7:0] d, output int c, output bit z);
        c = 0;
        case (m)
            2'b00: while (c < 8 && !d[c]) c++;
            2'b01: while (c < 8 && !d[7-c]) c++;
            2'b10: c = $countones(d);
            default: c = 8 - $countones(d);
        endcase
        z = (m[1] == 1'b0) ? (d == 8'h00) : (c == 0);
    endtask

    vec_t vt[9] = '{
        '{CIX_CTZ,  32'h0000_0100,  8, 1'b0, 2},
        '{CIX_CLZ,  32'h0000_0001, 31, 1'b0, 4},
        '{CIX_CLZ,  32'h8000_0000,  0, 1'b0, 1},
        '{CIX_POP1, 32'hF0F0_0001,  9, 1'b0, 4},
        '{CIX_POP0, 32'hF0F0_0001, 23, 1'b0, 4},
        '{CIX_POP0, 32'hFFFF_FFFF,  0, 1'b1, 4},
        '{CIX_CTZ,  32'h0000_0000, 32, 1'b1, 4},
        '{CIX_CLZ,  32'h0000_0000, 32, 1'b1, 4},
        '{CIX_CTZ,  32'h8000_0000, 31, 1'b0, 4}
    };

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : drive
        int t0, t0b, h, n, c;
        bit z;
        a_iv = 1'b0; a_mode = 2'b00; a_data = '0; a_or = 1'b1;
        b_iv = 1'b0; b_mode = 2'b00; b_data = '0; b_or = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_out_valid", int'(a_ov), 0);
        chk("rst_out_count", int'(a_cnt), 0);
        chk("rst_out_zero",  int'(a_z), 0);
        chk("rst_in_ready",  int'(a_ir), 1);
        chk("rst_b_in_ready", int'(b_ir), 1);
        reset = 1'b0;

        foreach (vt[i]) begin
            issue_a(vt[i].m, vt[i].d, vt[i].c, vt[i].z, vt[i].lat, t0);
            wait_a();
        end

        // Backpressure: hold the result while a second request waits.
        a_or = 1'b0;
        issue_a(CIX_CTZ, 32'h0000_0100, 8, 1'b0, 2, t0);
        n = 0;
        while (!a_ov && n < 50) begin @(negedge clock); n++; end
        chk("bp_out_valid_seen", int'(a_ov), 1);
        a_iv = 1'b1; a_mode = CIX_POP1; a_data = 32'h0000_00FF;
        repeat (5) begin
            @(negedge clock);
            chk("bp_in_ready_low", int'(a_ir), 0);
            chk("bp_out_valid_held", int'(a_ov), 1);
        end
        a_or = 1'b1;
        @(posedge clock);
        #1 h = cyc;
        issue_a(CIX_POP1, 32'h0000_00FF, 8, 1'b0, 4, t0b);
        chk("bp_accept_edge", t0b, h + 1);
        wait_a();

        // Reset during the second BUSY cycle of a clz.
        issue_a(CIX_CLZ, 32'h0000_0001, 31, 1'b0, 4, t0);
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        chk("midrst_out_valid", int'(a_ov), 0);
        chk("midrst_in_ready", int'(a_ir), 1);
        qa.delete();
        @(negedge clock);
        reset = 1'b0;
        issue_a(CIX_CLZ, 32'h0001_0000, 15, 1'b0, 2, t0);
        wait_a();

        // WORDS=1: exhaustive sweep, single-cycle latency everywhere.
        for (int m = 0; m < 4; m++) begin
            for (int d = 0; d < 256; d++) begin
                model8(2'(m), 8'(d), c, z);
                issue_b(2'(m), 8'(d), c, z, 1);
                wait_b();
            end
        end

        chk("a_pending_results", qa.size(), 0);
        chk("b_pending_results", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
